// File: rtl/traffic_pkg.sv
// Shared types for the two-road intersection controller:
// lamp codes, FSM states and the state-to-lamp decode.
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    S_AG = 2'b00,
    S_AY = 2'b01,
    S_BG = 2'b10,
    S_BY = 2'b11
  } state_t;

  function automatic int cnt_width(int maxv);
    return (maxv < 1) ? 1 : $clog2(maxv + 1);
  endfunction

  function automatic light_t light_a(state_t s);
    light_t l;
    case (s)
      S_AG:    l = GREEN;
      S_AY:    l = YELLOW;
      default: l = RED;
    endcase
    return l;
  endfunction

  function automatic light_t light_b(state_t s);
    light_t l;
    case (s)
      S_BG:    l = GREEN;
      S_BY:    l = YELLOW;
      default: l = RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_dwell_timer.sv
// Saturating dwell counter with synchronous clear and
// asynchronous active-high reset.
module traffic_dwell_timer
  import traffic_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int MAXV  = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAXV);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q != MAXC) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_problem_fsm.sv
// Moore controller for a two-road intersection; the green road
// holds while its sensor reports traffic, then hands over via yellow.
module traffic_problem_fsm
  import traffic_pkg::*;
#(
  parameter int YELLOW_CYCLES = 1,
  parameter int MIN_GREEN     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  output logic [1:0] la,
  output logic [1:0] lb
);

  localparam int DMAX =
    ((YELLOW_CYCLES > MIN_GREEN) ? YELLOW_CYCLES : MIN_GREEN) - 1;
  localparam int DW = cnt_width(DMAX);
  localparam logic [31:0] YLAST = YELLOW_CYCLES - 1;
  localparam logic [31:0] GLAST = MIN_GREEN - 1;

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   cnt;
  logic [31:0]     dwell;
  logic            yel_done;
  logic            grn_done;
  logic            clr;

  // Counter restarts whenever the state is about to change.
  assign clr = (state_d != state_q);

  traffic_dwell_timer #(
    .WIDTH (DW),
    .MAXV  (DMAX)
  ) u_dwell (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (clr),
    .count_o (cnt)
  );

  assign dwell    = 32'(cnt);
  assign yel_done = (dwell == YLAST);
  assign grn_done = (dwell >= GLAST);

  always_comb begin
    state_d = S_AG;
    case (state_q)
      S_AG: state_d = (!ta && grn_done) ? S_AY : S_AG;
      S_AY: state_d = yel_done ? S_BG : S_AY;
      S_BG: state_d = (!tb && grn_done) ? S_BY : S_BG;
      S_BY: state_d = yel_done ? S_AG : S_BY;
      default: state_d = S_AG;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_AG;
    end else begin
      state_q <= state_d;
    end
  end

  assign la = light_a(state_q);
  assign lb = light_b(state_q);

endmodule

// File: tb/tb_traffic_problem_fsm.sv
// Bench for traffic_problem_fsm: directed steps plus random sensors,
// checked against a road/phase model for default and YELLOW=3 builds.
module tb_traffic_problem_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       ta;
  logic       tb;
  logic [1:0] la1, lb1, la3, lb3;

  int nassert = 0;
  int nfail   = 0;

  // Model k: which road is green (0=A,1=B), yellow phase, cycles in phase.
  int road [2];
  int yel  [2];
  int tm   [2];
  int ycyc [2] = '{1, 3};
  int mgrn [2] = '{1, 2};

  always #5 clk = ~clk;

  traffic_problem_fsm dut (
    .clk   (clk),
    .reset (reset),
    .ta    (ta),
    .tb    (tb),
    .la    (la1),
    .lb    (lb1)
  );

  traffic_problem_fsm #(
    .YELLOW_CYCLES (3),
    .MIN_GREEN     (2)
  ) dut3 (
    .clk   (clk),
    .reset (reset),
    .ta    (ta),
    .tb    (tb),
    .la    (la3),
    .lb    (lb3)
  );

  function automatic logic [1:0] exp_l(int k, int r);
    if (road[k] != r) return 2'b00;
    return (yel[k] != 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      road[k] = 0;
      yel[k]  = 0;
      tm[k]   = 0;
    end
  endtask

  task automatic model_step(logic a, logic b);
    logic sens;
    for (int k = 0; k < 2; k++) begin
      if (yel[k] != 0) begin
        if (tm[k] + 1 >= ycyc[k]) begin
          road[k] = 1 - road[k];
          yel[k]  = 0;
          tm[k]   = 0;
        end else begin
          tm[k]++;
        end
      end else begin
        sens = (road[k] == 0) ? a : b;
        if (!sens && tm[k] >= mgrn[k] - 1) begin
          yel[k] = 1;
          tm[k]  = 0;
        end else begin
          tm[k]++;
        end
      end
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_la1"}, la1, exp_l(0, 0));
    chk({tag, "_lb1"}, lb1, exp_l(0, 1));
    chk({tag, "_la3"}, la3, exp_l(1, 0));
    chk({tag, "_lb3"}, lb3, exp_l(1, 1));
    nassert++;
    assert ((la1 == 2'b00 || lb1 == 2'b00) &&
            (la3 == 2'b00 || lb3 == 2'b00)) else begin
      nfail++;
      $error("FAIL %s_conflict observed=%b%b/%b%b expected=one red",
             tag, la1, lb1, la3, lb3);
    end
  endtask

  task automatic cyc(logic a, logic b, string tag);
    ta = a;
    tb = b;
    @(posedge clk);
    if (!reset) model_step(a, b);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    int ycount;
    reset = 1'b1;
    ta    = 1'b0;
    tb    = 1'b0;
    model_reset();
    #1;
    chk("rst_t1_la", la1, 2'b10);
    chk("rst_t1_lb", lb1, 2'b00);
    check_all("rst_t1");
    @(negedge clk);
    chk("rst_t10_la", la1, 2'b10);
    reset = 1'b0;

    cyc(1'b0, 1'b0, "s2_e15");
    chk("s2_e15_la", la1, 2'b01);
    chk("s2_e15_lb", lb1, 2'b00);
    cyc(1'b0, 1'b0, "s2_e25");
    chk("s2_e25_la", la1, 2'b00);
    chk("s2_e25_lb", lb1, 2'b10);

    cyc(1'b1, 1'b0, "s3_e35");
    chk("s3_e35_lb", lb1, 2'b01);
    cyc(1'b1, 1'b0, "s3_e45");
    chk("s3_e45_la", la1, 2'b10);

    cyc(1'b0, 1'b1, "s4_e55");
    chk("s4_e55_la", la1, 2'b01);
    cyc(1'b0, 1'b1, "s4_e65");
    chk("s4_e65_lb", lb1, 2'b10);
    cyc(1'b0, 1'b1, "s4_e75");
    chk("s4_e75_lb", lb1, 2'b10);

    cyc(1'b0, 1'b0, "s5_by");
    cyc(1'b1, 1'b0, "s5_ag");
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, "s5_hold");
      chk("s5_hold_la", la1, 2'b10);
    end
    cyc(1'b0, 1'b0, "s5_drop");
    chk("s5_drop_la", la1, 2'b01);

    cyc(1'b0, 1'b1, "s6_bg");
    chk("s6_bg_lb", lb1, 2'b10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("s6_async_la", la1, 2'b10);
    chk("s6_async_lb", lb1, 2'b00);
    check_all("s6_async");
    @(negedge clk);
    reset = 1'b0;

    ycount = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, "y3");
      if (la3 == 2'b01) ycount++;
    end
    nassert++;
    assert (ycount === 3) else begin
      nfail++;
      $error("FAIL y3_len observed=%0d expected=3", ycount);
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("rnd_rst");
        @(negedge clk);
        reset = 1'b0;
      end
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
          "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
